// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
// State codes are fixed because hz_state is visible at the module boundary.
package hazard_pkg;

   localparam int CNT_W_DEF   = 16;
   localparam int TIMEOUT_DEF = 255;
   localparam int WAIT_W      = 8;
   localparam int REG_W       = 5;

   typedef enum logic [1:0] {
      HZ_RUN       = 2'd0,
      HZ_LU_BUBBLE = 2'd1,
      HZ_MEM_WAIT  = 2'd2,
      HZ_ILLEGAL   = 2'd3
   } hz_state_e;

   typedef struct packed {
      logic stall_f;
      logic stall_d;
      logic stall_e;
      logic stall_m;
      logic flush_d;
      logic flush_e;
      logic flush_w;
   } hz_ctrl_t;

   localparam hz_ctrl_t HZ_CTRL_IDLE = '0;

   // x0 is hardwired zero, so a load targeting it can never feed a consumer.
   function automatic logic load_use_hit(
      input logic             mem_read,
      input logic [REG_W-1:0] rd,
      input logic [REG_W-1:0] rs1,
      input logic [REG_W-1:0] rs2,
      input logic             use_rs1,
      input logic             use_rs2
   );
      return mem_read && (rd != '0) &&
             ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, data-memory
// wait stalls with a sticky watchdog, plus stall/flush performance counters.
//
// state        | meaning
// -------------+---------------------------------------------------------
// RUN          | normal issue; load-use and branch rules active
// LU_BUBBLE    | one-cycle bubble after a load-use stall; load-use masked
// MEM_WAIT     | data memory busy last cycle; RUN rules apply once it frees
// ILLEGAL (3)  | unreachable code; returns to RUN on the next edge
module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             memReadE,
   input  logic             regWriteE,
   input  logic [REG_W-1:0] write_regE,
   input  logic [REG_W-1:0] read_reg1D,
   input  logic [REG_W-1:0] read_reg2D,
   input  logic             useRs1D,
   input  logic             useRs2D,
   input  logic             pcSrcE,
   input  logic             dmem_busy,
   output logic             stallF,
   output logic             stallD,
   output logic             stallE,
   output logic             stallM,
   output logic             flushD,
   output logic             flushE,
   output logic             flushW,
   output logic [1:0]       hz_state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             mem_timeout
);

   localparam logic [WAIT_W-1:0] TIMEOUT_CMP = WAIT_W'(TIMEOUT - 1);

   hz_state_e         state_q, state_d;
   hz_ctrl_t          ctrl;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              timeout_q, timeout_d;
   logic              lu_hit;
   logic              lu_eff;

   // A load always writes its destination, so regWriteE adds nothing to the hit.
   logic              unused_reg_write;
   assign unused_reg_write = regWriteE;

   assign lu_hit = load_use_hit(memReadE, write_regE, read_reg1D, read_reg2D,
                                useRs1D, useRs2D);
   assign lu_eff = lu_hit && (state_q != HZ_LU_BUBBLE);

   always_comb begin
      ctrl    = HZ_CTRL_IDLE;
      state_d = HZ_RUN;
      if (!rst_n) begin
         ctrl    = HZ_CTRL_IDLE;
         state_d = HZ_RUN;
      end else if (dmem_busy) begin
         ctrl.stall_f = 1'b1;
         ctrl.stall_d = 1'b1;
         ctrl.stall_e = 1'b1;
         ctrl.stall_m = 1'b1;
         ctrl.flush_w = 1'b1;
         state_d      = HZ_MEM_WAIT;
      end else if (pcSrcE) begin
         ctrl.flush_d = 1'b1;
         ctrl.flush_e = 1'b1;
         state_d      = HZ_RUN;
      end else if (lu_eff) begin
         ctrl.stall_f = 1'b1;
         ctrl.stall_d = 1'b1;
         ctrl.flush_e = 1'b1;
         state_d      = HZ_LU_BUBBLE;
      end
      if (state_q == HZ_ILLEGAL) begin
         state_d = HZ_RUN;
      end
   end

   // Wait counter holds at its ceiling so a very long stall cannot wrap past TIMEOUT-1.
   always_comb begin
      wait_d    = '0;
      timeout_d = timeout_q;
      if (dmem_busy) begin
         wait_d = (wait_q == '1) ? wait_q : (wait_q + WAIT_W'(1));
         if (wait_q == TIMEOUT_CMP) begin
            timeout_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= HZ_RUN;
         wait_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
      end
   end

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (ctrl.stall_f),
      .count (stall_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (ctrl.flush_d),
      .count (flush_cnt)
   );

   assign stallF      = ctrl.stall_f;
   assign stallD      = ctrl.stall_d;
   assign stallE      = ctrl.stall_e;
   assign stallM      = ctrl.stall_m;
   assign flushD      = ctrl.flush_d;
   assign flushE      = ctrl.flush_e;
   assign flushW      = ctrl.flush_w;
   assign hz_state    = state_q;
   assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a rule-level model.
module tb_hazard_stall_ctrl;

   localparam int CNT_W   = 4;
   localparam int TIMEOUT = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             memReadE, regWriteE, useRs1D, useRs2D, pcSrcE, dmem_busy;
   logic [4:0]       write_regE, read_reg1D, read_reg2D;
   logic             stallF, stallD, stallE, stallM, flushD, flushE, flushW;
   logic [1:0]       hz_state;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic             mem_timeout;

   hazard_stall_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .memReadE    (memReadE),
      .regWriteE   (regWriteE),
      .write_regE  (write_regE),
      .read_reg1D  (read_reg1D),
      .read_reg2D  (read_reg2D),
      .useRs1D     (useRs1D),
      .useRs2D     (useRs2D),
      .pcSrcE      (pcSrcE),
      .dmem_busy   (dmem_busy),
      .stallF      (stallF),
      .stallD      (stallD),
      .stallE      (stallE),
      .stallM      (stallM),
      .flushD      (flushD),
      .flushE      (flushE),
      .flushW      (flushW),
      .hz_state    (hz_state),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt),
      .mem_timeout (mem_timeout)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic int stalls_now();
      return int'({stallF, stallD, stallE, stallM});
   endfunction

   function automatic int flushes_now();
      return int'({flushD, flushE, flushW});
   endfunction

   task automatic expect_out(input string name, input int st, input int fl, input int hz,
                             input int scnt, input int fcnt, input int to);
      check({name, ".stalls"},   stalls_now(),     st);
      check({name, ".flushes"},  flushes_now(),    fl);
      check({name, ".hz_state"}, int'(hz_state),   hz);
      check({name, ".stall_cnt"}, int'(stall_cnt), scnt);
      check({name, ".flush_cnt"}, int'(flush_cnt), fcnt);
      check({name, ".timeout"},  int'(mem_timeout), to);
   endtask

   // Model: what the previous cycle decided (0 none, 1 load-use stall, 2 memory
   // wait), counters as plain integers, wait run length and sticky error.
   int m_last = 0, m_stall = 0, m_flush = 0, m_wait = 0, m_to = 0;
   int n_last, n_stall, n_flush, n_wait, n_to;
   int e_st, e_fl, lu;

   always @(negedge clk) begin
      if (!rst_n) begin
         check("cmp_rst.stalls",   stalls_now(),  0);
         check("cmp_rst.flushes",  flushes_now(), 0);
         check("cmp_rst.hz_state", int'(hz_state), 0);
         check("cmp_rst.counts",   int'(stall_cnt) + int'(flush_cnt), 0);
         check("cmp_rst.timeout",  int'(mem_timeout), 0);
      end else begin
         lu = (memReadE && write_regE != 0 &&
               ((useRs1D && read_reg1D == write_regE) ||
                (useRs2D && read_reg2D == write_regE))) ? 1 : 0;
         e_st = 0; e_fl = 0; n_last = 0;
         if (dmem_busy) begin
            e_st = 4'b1111; e_fl = 3'b001; n_last = 2;
         end else if (pcSrcE) begin
            e_fl = 3'b110;
         end else if (lu == 1 && m_last != 1) begin
            e_st = 4'b1100; e_fl = 3'b010; n_last = 1;
         end
         check("cmp.stalls",    stalls_now(),       e_st);
         check("cmp.flushes",   flushes_now(),      e_fl);
         check("cmp.hz_state",  int'(hz_state),     m_last);
         check("cmp.stall_cnt", int'(stall_cnt),    m_stall);
         check("cmp.flush_cnt", int'(flush_cnt),    m_flush);
         check("cmp.timeout",   int'(mem_timeout),  m_to);
         n_stall = e_st[3] ? imin(m_stall + 1, CNT_MAX) : m_stall;
         n_flush = e_fl[2] ? imin(m_flush + 1, CNT_MAX) : m_flush;
         n_wait  = dmem_busy ? imin(m_wait + 1, 255) : 0;
         n_to    = (m_to == 1 || (dmem_busy && m_wait == TIMEOUT - 1)) ? 1 : 0;
      end
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         m_last = 0; m_stall = 0; m_flush = 0; m_wait = 0; m_to = 0;
      end else begin
         m_last = n_last; m_stall = n_stall; m_flush = n_flush;
         m_wait = n_wait; m_to = n_to;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      memReadE = 0; regWriteE = 0; useRs1D = 0; useRs2D = 0;
      pcSrcE = 0; dmem_busy = 0;
      write_regE = 0; read_reg1D = 0; read_reg2D = 0;
   endtask

   task automatic set_lu();
      memReadE = 1; regWriteE = 1; write_regE = 5;
      read_reg1D = 7; useRs1D = 1; read_reg2D = 5; useRs2D = 1;
   endtask

   task automatic do_reset();
      rst_n = 0;
      tick();
      rst_n = 1;
   endtask

   int burst = 0;

   initial begin
      clr_in();
      tick();
      // Hazards presented during reset must not reach the outputs.
      set_lu(); pcSrcE = 1; dmem_busy = 1;
      @(negedge clk); expect_out("reset_hold", 0, 0, 0, 0, 0, 0);
      tick();
      clr_in(); rst_n = 1;

      // Load x5, consumer reads x5 on rs2.
      set_lu();
      @(negedge clk); expect_out("lu_stall", 4'b1100, 3'b010, 0, 0, 0, 0);
      tick();
      @(negedge clk); expect_out("lu_bubble", 0, 0, 1, 1, 0, 0);
      tick(); clr_in();
      @(negedge clk); expect_out("lu_after", 0, 0, 0, 1, 0, 0);
      tick();

      // Load to x0 never stalls.
      do_reset();
      memReadE = 1; write_regE = 0; read_reg1D = 0; useRs1D = 1; read_reg2D = 0; useRs2D = 1;
      @(negedge clk); expect_out("x0_load", 0, 0, 0, 0, 0, 0);
      tick();
      @(negedge clk); expect_out("x0_next", 0, 0, 0, 0, 0, 0);
      tick(); clr_in();

      // Branch wins over load-use.
      do_reset();
      set_lu(); pcSrcE = 1;
      @(negedge clk); expect_out("br_lu", 0, 3'b110, 0, 0, 0, 0);
      tick(); clr_in();
      @(negedge clk); expect_out("br_lu_next", 0, 0, 0, 0, 1, 0);
      tick();

      // Memory busy for three cycles with a branch held in EX.
      do_reset();
      dmem_busy = 1; pcSrcE = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); expect_out("busy_br", 4'b1111, 3'b001, (i == 0) ? 0 : 2, i, 0, 0);
         tick();
      end
      dmem_busy = 0;
      @(negedge clk); expect_out("br_release", 0, 3'b110, 2, 3, 0, 0);
      tick(); pcSrcE = 0;
      @(negedge clk); expect_out("br_done", 0, 0, 0, 3, 1, 0);
      tick();

      // Watchdog with TIMEOUT=4: sets on the 4th busy edge and stays set.
      do_reset();
      dmem_busy = 1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         expect_out("wd_busy", 4'b1111, 3'b001, (k == 1) ? 0 : 2, k - 1, 0, (k >= 5) ? 1 : 0);
         tick();
      end
      dmem_busy = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("wd_sticky", int'(mem_timeout), 1);
         check("wd_sticky.stalls", stalls_now(), 0);
         tick();
      end
      rst_n = 0;
      #1 check("wd_reset", int'(mem_timeout), 0);
      tick(); rst_n = 1;

      // Twenty load-use events saturate the 4-bit stall counter.
      set_lu();
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         check("sat_stall", int'(stallF), 1);
         check("sat_stall.cnt", int'(stall_cnt), imin(k - 1, CNT_MAX));
         tick();
         @(negedge clk);
         check("sat_bubble.hz", int'(hz_state), 1);
         check("sat_bubble.cnt", int'(stall_cnt), imin(k, CNT_MAX));
         tick();
      end
      @(negedge clk); check("sat_pre_rst", int'(stallF), 1);
      #2 rst_n = 0;
      #1 expect_out("async_rst", 0, 0, 0, 0, 0, 0);
      tick(); rst_n = 1;
      @(negedge clk); expect_out("post_rst", 4'b1100, 3'b010, 0, 0, 0, 0);
      tick(); clr_in();

      // Reset in the middle of a memory wait.
      dmem_busy = 1;
      tick(); tick();
      @(negedge clk); check("mw_pre.hz", int'(hz_state), 2);
      #1 rst_n = 0;
      #1 check("mw_rst.hz", int'(hz_state), 0);
      check("mw_rst.stalls", stalls_now(), 0);
      tick(); rst_n = 1;
      @(negedge clk); expect_out("mw_release", 4'b1111, 3'b001, 0, 0, 0, 0);
      tick(); clr_in();

      // Randomized traffic; the compare process checks every cycle.
      for (int c = 0; c < 3000; c++) begin
         rst_n = ($urandom_range(0, 249) != 0);
         if (burst > 0) begin
            dmem_busy = 1; burst--;
         end else if ($urandom_range(0, 29) == 0) begin
            dmem_busy = 1; burst = $urandom_range(1, 7);
         end else begin
            dmem_busy = ($urandom_range(0, 9) == 0);
         end
         pcSrcE     = ($urandom_range(0, 7) == 0);
         memReadE   = $urandom_range(0, 1) == 1;
         regWriteE  = $urandom_range(0, 1) == 1;
         write_regE = 5'($urandom_range(0, 3));
         read_reg1D = 5'($urandom_range(0, 3));
         read_reg2D = 5'($urandom_range(0, 3));
         useRs1D    = $urandom_range(0, 1) == 1;
         useRs2D    = $urandom_range(0, 1) == 1;
         tick();
      end
      rst_n = 1; clr_in();
      tick();
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
